// File: rtl/leaf_gen_pkg.sv
// Shared definitions for the leaf generator and its consumers.
//   pool_op_e      : per-cycle bit-pool operation, encoded as {accept, extract}
//   pool_cnt_width : bits needed to hold a pool fill level 0..pool_width
package leaf_gen_pkg;

    typedef enum logic [1:0] {
        PoolIdle  = 2'b00,
        PoolDrain = 2'b01,
        PoolFill  = 2'b10,
        PoolBoth  = 2'b11
    } pool_op_e;

    function automatic int unsigned pool_cnt_width(input int unsigned pool_width);
        return $clog2(pool_width + 1);
    endfunction

endpackage

// File: rtl/leaf_gen_fifo.sv
// First-word-fall-through FIFO holding leaf labels.
//   Clock, Reset : clock, synchronous active-low reset (empties the FIFO)
//   push, wdata  : write request and data; ignored when full
//   pop          : read request; ignored when empty
//   rdata        : head entry, valid whenever empty is low
//   full, empty  : occupancy flags
//   count        : registered occupancy 0..Depth
module leaf_gen_fifo #(
    parameter int unsigned Width = 20,
    parameter int unsigned Depth = 4
) (
    input  logic                     Clock,
    input  logic                     Reset,
    input  logic                     push,
    input  logic [Width-1:0]         wdata,
    input  logic                     pop,
    output logic [Width-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(Depth):0]   count
);

    localparam int unsigned PtrWidth = $clog2(Depth);
    localparam int unsigned CntWidth = PtrWidth + 1;
    localparam logic [CntWidth-1:0] DepthCnt = CntWidth'(Depth);

    logic [Width-1:0]    mem_q [Depth];
    logic [PtrWidth-1:0] wr_ptr_q, rd_ptr_q;
    logic [CntWidth-1:0] count_q;
    logic                do_push, do_pop;

    assign full    = (count_q == DepthCnt);
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem_q[rd_ptr_q];
    assign count   = count_q;

    // Depth is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge Clock) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/leaf_gen.sv
// Repacks random words from the PRNG into ORAML-bit leaf labels, LSB-first,
// without discarding bits, and buffers up to Depth leaves for the backend.
//   Clock, Reset              : clock, synchronous active-low reset
//   RandInValid/Ready, RandIn : random word input handshake
//   LeafOutValid/Ready, LeafOut : leaf output handshake (FIFO head)
//   LeafCount                 : registered number of buffered leaves
//   Starved                   : registered pulse after a request found no leaf
module leaf_gen
    import leaf_gen_pkg::*;
#(
    parameter int unsigned RandWidth = 32,
    parameter int unsigned ORAML     = 20,
    parameter int unsigned Depth     = 4
) (
    input  logic                   Clock,
    input  logic                   Reset,
    input  logic                   RandInValid,
    output logic                   RandInReady,
    input  logic [RandWidth-1:0]   RandIn,
    output logic                   LeafOutValid,
    input  logic                   LeafOutReady,
    output logic [ORAML-1:0]       LeafOut,
    output logic [$clog2(Depth):0] LeafCount,
    output logic                   Starved
);

    localparam int unsigned PoolWidth    = RandWidth + ORAML;
    localparam int unsigned PoolCntWidth = pool_cnt_width(PoolWidth);
    localparam logic [PoolCntWidth-1:0] LeafBits = PoolCntWidth'(ORAML);
    localparam logic [PoolCntWidth-1:0] RandBits = PoolCntWidth'(RandWidth);

    logic [PoolWidth-1:0]    pool_q, pool_d;
    logic [PoolCntWidth-1:0] pool_cnt_q, pool_cnt_d;
    logic                    starved_q;
    logic [PoolWidth-1:0]    rand_ext;
    logic                    accept, extract, pop;
    logic                    fifo_full, fifo_empty;
    logic [$clog2(Depth):0]  fifo_count;
    pool_op_e                pool_op;

    // Ready depends only on the pool level, so a full word always fits above
    // the bits already held.
    assign RandInReady = Reset && (pool_cnt_q <= LeafBits);
    assign accept      = RandInValid && RandInReady;
    // Extraction looks at pre-pop fullness; a same-cycle pop does not free a slot.
    assign extract     = Reset && (pool_cnt_q >= LeafBits) && !fifo_full;
    assign pop         = Reset && LeafOutReady && !fifo_empty;
    assign rand_ext    = {{ORAML{1'b0}}, RandIn};
    assign pool_op     = pool_op_e'({accept, extract});

    // Bits above pool_cnt_q are always zero, so inserting with OR is exact.
    always_comb begin
        pool_d     = pool_q;
        pool_cnt_d = pool_cnt_q;
        case (pool_op)
            PoolFill: begin
                pool_d     = pool_q | (rand_ext << pool_cnt_q);
                pool_cnt_d = pool_cnt_q + RandBits;
            end
            PoolDrain: begin
                pool_d     = pool_q >> ORAML;
                pool_cnt_d = pool_cnt_q - LeafBits;
            end
            PoolBoth: begin
                pool_d     = (pool_q >> ORAML) | (rand_ext << (pool_cnt_q - LeafBits));
                pool_cnt_d = pool_cnt_q + RandBits - LeafBits;
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            pool_q     <= '0;
            pool_cnt_q <= '0;
            starved_q  <= 1'b0;
        end else begin
            pool_q     <= pool_d;
            pool_cnt_q <= pool_cnt_d;
            starved_q  <= LeafOutReady && fifo_empty;
        end
    end

    leaf_gen_fifo #(
        .Width (ORAML),
        .Depth (Depth)
    ) u_fifo (
        .Clock (Clock),
        .Reset (Reset),
        .push  (extract),
        .wdata (pool_q[ORAML-1:0]),
        .pop   (pop),
        .rdata (LeafOut),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Registered state can be stale during the reset cycle itself; mask it.
    assign LeafOutValid = Reset && !fifo_empty;
    assign LeafCount    = Reset ? fifo_count : '0;
    assign Starved      = Reset && starved_q;

endmodule

// File: tb/tb_leaf_gen.sv
module tb_leaf_gen;

    logic        Clock = 1'b0;
    logic        Reset = 1'b0;
    logic        RandInValid = 1'b0;
    logic        RandInReady;
    logic [31:0] RandIn = '0;
    logic        LeafOutValid;
    logic        LeafOutReady = 1'b0;
    logic [19:0] LeafOut;
    logic [2:0]  LeafCount;
    logic        Starved;

    always #5 Clock = ~Clock;

    leaf_gen #(
        .RandWidth (32),
        .ORAML     (20),
        .Depth     (4)
    ) dut (
        .Clock        (Clock),
        .Reset        (Reset),
        .RandInValid  (RandInValid),
        .RandInReady  (RandInReady),
        .RandIn       (RandIn),
        .LeafOutValid (LeafOutValid),
        .LeafOutReady (LeafOutReady),
        .LeafOut      (LeafOut),
        .LeafCount    (LeafCount),
        .Starved      (Starved)
    );

    int n_pass  = 0;
    int n_total = 0;

    logic [19:0] exp_q [$];   // scoreboard of expected leaves
    logic [31:0] wq [$];      // words waiting to be offered
    bit          model_en  = 1'b0;
    bit          rand_mode = 1'b0;
    logic [63:0] m_bits = '0;
    int          m_cnt  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    endtask

    // Reference bit stream: append word LSB-first, emit every full 20-bit leaf.
    task automatic model_accept(input logic [31:0] w);
        m_bits = m_bits | ({32'b0, w} << m_cnt);
        m_cnt += 32;
        while (m_cnt >= 20) begin
            exp_q.push_back(m_bits[19:0]);
            m_bits = m_bits >> 20;
            m_cnt -= 20;
        end
    endtask

    // Monitor: word acceptance and leaf delivery, sampled mid-cycle.
    always @(negedge Clock) begin
        if (Reset && RandInValid && RandInReady) begin
            if (model_en) model_accept(RandIn);
            if (wq.size() > 0) void'(wq.pop_front());
        end
        if (LeafOutValid && LeafOutReady) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL leaf_extra: got 0x%0h, expected no leaf", LeafOut);
            end else begin
                check("leaf", {44'b0, LeafOut}, {44'b0, exp_q.pop_front()});
            end
        end
    end

    // Driver: offer the head of wq; random mode also throttles both sides.
    always @(posedge Clock) begin
        #1;
        if (wq.size() > 0 && (!rand_mode || $urandom_range(0, 3) != 0)) begin
            RandInValid = 1'b1;
            RandIn      = wq[0];
        end else begin
            RandInValid = 1'b0;
            RandIn      = '0;
        end
        if (rand_mode) LeafOutReady = ($urandom_range(0, 2) != 0);
    end

    task automatic flush_model();
        wq.delete();
        exp_q.delete();
        m_bits = '0;
        m_cnt  = 0;
    endtask

    task automatic do_reset();
        @(posedge Clock); #2;
        Reset = 1'b0;
        flush_model();
        @(posedge Clock); #2;
        Reset = 1'b1;
    endtask

    task automatic wait_drain(input string name, input int max_cycles);
        int i = 0;
        while ((exp_q.size() != 0 || wq.size() != 0) && i < max_cycles) begin
            @(posedge Clock);
            i++;
        end
        check(name, 64'(exp_q.size() + wq.size()), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got no finish, expected finish before 1ms");
        $fatal(1, "timeout");
    end

    initial begin
        int popped;
        int guard;

        // Reset state
        repeat (2) @(posedge Clock);
        @(negedge Clock);
        check("rst_valid", {63'b0, LeafOutValid}, 64'd0);
        check("rst_count", {61'b0, LeafCount}, 64'd0);
        check("rst_starved", {63'b0, Starved}, 64'd0);
        check("rst_ready", {63'b0, RandInReady}, 64'd0);
        @(posedge Clock); #2;
        Reset = 1'b1;
        @(negedge Clock);
        check("post_rst_ready", {63'b0, RandInReady}, 64'd1);

        // 1: two words, hand-computed leaves
        model_en = 1'b0;
        LeafOutReady = 1'b1;
        exp_q.push_back(20'h45678);
        exp_q.push_back(20'hF0123);
        exp_q.push_back(20'hABCDE);
        wq.push_back(32'h1234_5678);
        wq.push_back(32'h9ABC_DEF0);
        wait_drain("t1_drain", 100);
        repeat (3) @(posedge Clock);
        @(negedge Clock);
        check("t1_pool_cnt", 64'(dut.pool_cnt_q), 64'd4);
        check("t1_pool", 64'(dut.pool_q), 64'h9);

        // 2/3: saturate, then pop while full with extract pending
        LeafOutReady = 1'b0;
        do_reset();
        model_en = 1'b1;
        for (int i = 0; i < 10; i++) wq.push_back(32'h1357_9BDF ^ (i * 32'h0101_0101));
        repeat (30) @(posedge Clock);
        @(negedge Clock);
        check("t2_count_full", {61'b0, LeafCount}, 64'd4);
        check("t2_ready_low", {63'b0, RandInReady}, 64'd0);
        check("t2_valid", {63'b0, LeafOutValid}, 64'd1);
        check("t2_pool_range", 64'(dut.pool_cnt_q >= 20 && dut.pool_cnt_q <= 52), 64'd1);
        @(posedge Clock); #2;
        LeafOutReady = 1'b1;
        @(posedge Clock); #2;
        LeafOutReady = 1'b0;
        @(negedge Clock);
        check("t3_push_blocked", {61'b0, LeafCount}, 64'd3);
        @(negedge Clock);
        check("t3_push_next", {61'b0, LeafCount}, 64'd4);
        @(posedge Clock); #2;
        LeafOutReady = 1'b1;
        wait_drain("t2_drain", 300);
        repeat (4) @(posedge Clock);
        @(negedge Clock);
        check("t2_pool_empty", 64'(dut.pool_cnt_q), 64'd0);

        // 4: starvation
        LeafOutReady = 1'b0;
        do_reset();
        @(posedge Clock); #2;
        LeafOutReady = 1'b1;
        @(negedge Clock);
        check("t4_starved_before", {63'b0, Starved}, 64'd0);
        @(negedge Clock);
        check("t4_starved", {63'b0, Starved}, 64'd1);
        check("t4_valid", {63'b0, LeafOutValid}, 64'd0);
        @(posedge Clock); #2;
        LeafOutReady = 1'b0;
        @(negedge Clock);
        @(negedge Clock);
        check("t4_starved_clear", {63'b0, Starved}, 64'd0);

        // 5: reset mid-stream with 12 pool bits and 3 leaves buffered
        model_en = 1'b1;
        for (int i = 0; i < 6; i++) wq.push_back(32'hA5A5_0001 + i * 32'h0F0F_0F0F);
        popped = 0;
        guard  = 0;
        while (popped < 6 && guard < 200) begin
            @(posedge Clock); #2;
            LeafOutReady = 1'b0;
            if (LeafOutValid) begin
                LeafOutReady = 1'b1;
                popped++;
            end
            guard++;
        end
        @(posedge Clock); #2;
        LeafOutReady = 1'b0;
        check("t5_popped", 64'(popped), 64'd6);
        repeat (20) @(posedge Clock);
        @(negedge Clock);
        check("t5_pre_pool_cnt", 64'(dut.pool_cnt_q), 64'd12);
        check("t5_pre_count", {61'b0, LeafCount}, 64'd3);
        @(posedge Clock); #2;
        Reset = 1'b0;
        flush_model();
        @(negedge Clock);
        check("t5_rst_valid", {63'b0, LeafOutValid}, 64'd0);
        check("t5_rst_ready", {63'b0, RandInReady}, 64'd0);
        @(posedge Clock); #2;
        Reset = 1'b1;
        @(negedge Clock);
        check("t5_pool_cnt", 64'(dut.pool_cnt_q), 64'd0);
        check("t5_count", {61'b0, LeafCount}, 64'd0);
        check("t5_valid", {63'b0, LeafOutValid}, 64'd0);
        model_en = 1'b0;
        exp_q.push_back(20'hDF00D);
        wq.push_back(32'h0BAD_F00D);
        LeafOutReady = 1'b1;
        wait_drain("t5_drain", 100);
        repeat (3) @(posedge Clock);
        @(negedge Clock);
        check("t5_pool_left", 64'(dut.pool_q), 64'hBA);

        // 6: random handshakes against the bit-stream model
        LeafOutReady = 1'b0;
        do_reset();
        model_en  = 1'b1;
        rand_mode = 1'b1;
        for (int i = 0; i < 300; i++) wq.push_back($urandom);
        wait_drain("t6_drain", 5000);
        rand_mode = 1'b0;
        @(posedge Clock); #2;
        LeafOutReady = 1'b0;
        repeat (4) @(posedge Clock);
        @(negedge Clock);
        check("t6_pool_cnt", 64'(dut.pool_cnt_q), 64'(m_cnt));
        check("t6_pool_bits", 64'(dut.pool_q), m_bits);
        check("t6_count", {61'b0, LeafCount}, 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
